// File: rtl/beagleg_spi_host.sv
// -----------------------------------------------------------------------------
// beagleg_spi_host
//
// SPI main-side transmitter for the BeagleG motion protocol (SPI mode 0).
// It issues CMD_STATUS (0x01) or CMD_WRITE_FIFO (0x02) transactions. A write
// sends the command byte followed by RecordWords payload bytes, byte 0 first.
// The byte returned by the secondary during every command byte is latched
// into free_slots.
//
// Parameters:
//   ClkDiv       SCK half-period in clk cycles (>= 2; >= 4 if the secondary
//                oversamples SCK in its own clock domain)
//   RecordWords  payload bytes per motion segment
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   seg_valid    segment offered
//   seg_ready    one-cycle pulse: segment accepted and fully transmitted
//   seg_data     segment payload, byte 0 = bits [7:0]
//   status_req   status poll request (level, sampled while idle, has priority)
//   done         one-cycle pulse at the end of every transaction
//   aborted      one-cycle pulse with done when a write was abandoned
//   free_slots   last free-slot count received from the secondary
//   busy         high from transaction start until done
//   spi_sck      SPI clock, idles low
//   spi_mosi     main-out data, MSB first
//   spi_cs       chip select, active low
//   spi_miso     secondary-out data
//
// Configuration macro:
//   BEAGLEG_SPI_HOST_FULL_CHECK_EN  when defined, a write whose command byte
//   reports zero free slots skips its payload and pulses aborted; the segment
//   stays pending. When undefined the payload is always sent and aborted is 0.
// -----------------------------------------------------------------------------
module beagleg_spi_host #(
    parameter int ClkDiv      = 4,
    parameter int RecordWords = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     seg_valid,
    output logic                     seg_ready,
    input  logic [8*RecordWords-1:0] seg_data,
    input  logic                     status_req,
    output logic                     done,
    output logic                     aborted,
    output logic [7:0]               free_slots,
    output logic                     busy,
    output logic                     spi_sck,
    output logic                     spi_mosi,
    output logic                     spi_cs,
    input  logic                     spi_miso
);

    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int BcW  = $clog2(RecordWords + 1);

    localparam logic [7:0] CMD_STATUS     = 8'h01;
    localparam logic [7:0] CMD_WRITE_FIFO = 8'h02;

    // BYTE_END is a zero-cycle decision taken on the last SHIFT cycle of a
    // byte, so it has no encoding of its own: bytes run back-to-back.
    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_IDLE
    } state_t;

    state_t state, state_nx;

    logic [DivW-1:0]          div_cnt;
    logic                     phase;      // 0: SCK-low half, 1: SCK-high half
    logic [2:0]               bit_cnt;
    logic [BcW-1:0]           byte_cnt;   // 0 = command, k = payload byte k-1
    logic [7:0]               tx_sr;
    logic [6:0]               rx_sr;
    logic [8*RecordWords-1:0] seg_q;
    logic                     is_write;
    logic                     abort_q;
    logic [7:0]               next_byte;

    logic div_wrap;
    logic sck_rise;
    logic bit_end;
    logic byte_end;
    logic full_abort;
    logic more_bytes;
    logic start;

    assign div_wrap = (div_cnt == DivW'(ClkDiv - 1));
    assign sck_rise = (state == SHIFT) && div_wrap && !phase;
    assign bit_end  = (state == SHIFT) && div_wrap && phase;
    assign byte_end = bit_end && (bit_cnt == 3'd7);
    assign start    = (state == IDLE) && (status_req || seg_valid);

`ifdef BEAGLEG_SPI_HOST_FULL_CHECK_EN
    // free_slots was latched on the last SCK rise of the command byte, which
    // precedes the byte end by half a bit.
    assign full_abort = is_write && (byte_cnt == '0) && (free_slots == 8'd0);
`else
    assign full_abort = 1'b0;
`endif

    assign more_bytes = is_write && !full_abort && (byte_cnt != BcW'(RecordWords));

    assign spi_mosi = tx_sr[7];

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (status_req || seg_valid) state_nx = CS_SETUP;
            CS_SETUP: if (div_wrap)                state_nx = SHIFT;
            SHIFT:    if (byte_end && !more_bytes) state_nx = CS_HOLD;
            CS_HOLD:  if (div_wrap)                state_nx = CS_IDLE;
            CS_IDLE:  if (div_wrap && phase)       state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    // Payload byte that follows the byte just finished (index byte_cnt).
    always_comb begin
        next_byte = 8'h00;
        for (int i = 0; i < RecordWords; i++) begin
            if (byte_cnt == BcW'(i)) next_byte = seg_q[8*i +: 8];
        end
    end

    // NOTE: the asynchronous reset returns every output to its idle value at
    // once, so a reset mid-transaction raises CS without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            seg_q      <= '0;
            is_write   <= 1'b0;
            abort_q    <= 1'b0;
            free_slots <= '0;
            spi_sck    <= 1'b0;
            spi_cs     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            seg_ready  <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state     <= state_nx;
            done      <= 1'b0;
            seg_ready <= 1'b0;
            aborted   <= 1'b0;

            // Divider restarts on every state change; SHIFT->SHIFT at a byte
            // end keeps running, which keeps the bytes back-to-back.
            if (state == IDLE || state_nx != state) begin
                div_cnt <= '0;
                phase   <= 1'b0;
            end else if (div_wrap) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            spi_sck <= (state == SHIFT) && (phase ^ div_wrap);
            spi_cs  <= !(state_nx == CS_SETUP || state_nx == SHIFT || state_nx == CS_HOLD);
            busy    <= (state_nx != IDLE);

            if (start) begin
                is_write <= !status_req;
                abort_q  <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                tx_sr    <= status_req ? CMD_STATUS : CMD_WRITE_FIFO;
                if (!status_req) seg_q <= seg_data;
            end

            if (sck_rise) begin
                rx_sr <= {rx_sr[5:0], spi_miso};
                if (bit_cnt == 3'd7 && byte_cnt == '0) free_slots <= {rx_sr, spi_miso};
            end

            // MOSI moves on the SCK fall that ends each bit.
            if (bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_end && more_bytes) begin
                    tx_sr    <= next_byte;
                    byte_cnt <= byte_cnt + 1'b1;
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end

            if (byte_end && full_abort) abort_q <= 1'b1;

            if (state != IDLE && state_nx == IDLE) begin
                done      <= 1'b1;
                seg_ready <= is_write && !abort_q;
                aborted   <= abort_q;
            end
        end
    end

endmodule

// File: tb/tb_beagleg_spi_host.sv
// -----------------------------------------------------------------------------
// tb_beagleg_spi_host
//
// Self-checking bench for beagleg_spi_host at ClkDiv=4, RecordWords=4.
// A behavioural SPI secondary returns model_free MSB first during each byte
// and collects the MOSI bytes and SCK rising edges. A table of transactions
// is applied in a loop, followed by hand-written sequences for arbitration,
// reset mid-record and the full-FIFO case.
// -----------------------------------------------------------------------------
module tb_beagleg_spi_host;

    localparam int ClkDiv      = 4;
    localparam int RecordWords = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seg_valid;
    logic        seg_ready;
    logic [31:0] seg_data;
    logic        status_req;
    logic        done;
    logic        aborted;
    logic [7:0]  free_slots;
    logic        busy;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs;
    logic        spi_miso;

    beagleg_spi_host #(
        .ClkDiv      (ClkDiv),
        .RecordWords (RecordWords)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .seg_data   (seg_data),
        .status_req (status_req),
        .done       (done),
        .aborted    (aborted),
        .free_slots (free_slots),
        .busy       (busy),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural SPI secondary ----------------
    logic [7:0] model_free = 8'h00;
    logic [2:0] miso_idx   = 3'd0;
    logic [7:0] cap_sr     = 8'h00;
    int         cap_bits   = 0;
    int         sck_rises  = 0;
    logic [7:0] cap_q[$];

    // Mode 0: shift the next bit out on each SCK fall; restart on CS release.
    always @(negedge spi_sck or posedge spi_cs) begin
        if (spi_cs) miso_idx <= 3'd0;
        else        miso_idx <= miso_idx + 3'd1;
    end
    assign spi_miso = model_free[3'd7 - miso_idx];

    always @(posedge spi_sck or posedge spi_cs) begin
        if (spi_cs) begin
            cap_bits <= 0;
        end else begin
            sck_rises <= sck_rises + 1;
            cap_sr    <= {cap_sr[6:0], spi_mosi};
            if (cap_bits == 7) begin
                cap_q.push_back({cap_sr[6:0], spi_mosi});
                cap_bits <= 0;
            end else begin
                cap_bits <= cap_bits + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Waits for CS to fall one cycle after the request, then for done, and
    // checks everything reported at the done cycle. Returns on the negedge
    // of the done cycle; a granted segment is withdrawn right there.
    task automatic observe(input string name, input logic [39:0] exp_mosi,
                           input int exp_nbytes, input logic [7:0] exp_free,
                           input int exp_lat, input int exp_rises,
                           input logic exp_ready, input logic exp_abort);
        int          qstart;
        int          rises0;
        int          t0;
        int          budget;
        logic [39:0] got;
        qstart = cap_q.size();
        rises0 = sck_rises;
        @(negedge clk);
        check({name, " cs_fall"}, {63'd0, spi_cs}, 64'd0);
        if (spi_cs !== 1'b0) return;
        status_req = 1'b0;
        t0 = cyc;
        budget = 0;
        while (done !== 1'b1 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check({name, " done_seen"}, {63'd0, done}, 64'd1);
        if (done !== 1'b1) return;
        check({name, " latency"},    64'(cyc - t0),           64'(exp_lat));
        check({name, " free_slots"}, {56'd0, free_slots},     {56'd0, exp_free});
        check({name, " busy"},       {63'd0, busy},           64'd0);
        check({name, " seg_ready"},  {63'd0, seg_ready},      {63'd0, exp_ready});
        check({name, " aborted"},    {63'd0, aborted},        {63'd0, exp_abort});
        check({name, " sck_rises"},  64'(sck_rises - rises0), 64'(exp_rises));
        check({name, " nbytes"},     64'(cap_q.size() - qstart), 64'(exp_nbytes));
        got = '0;
        for (int i = 0; i < exp_nbytes && qstart + i < cap_q.size(); i++)
            got = {got[31:0], cap_q[qstart + i]};
        check({name, " mosi"}, {24'd0, got}, {24'd0, exp_mosi});
        if (seg_ready === 1'b1) seg_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        req_status;
        logic        req_write;
        logic [31:0] data;
        logic [7:0]  mfree;
        logic [39:0] exp_mosi;
        int          exp_nbytes;
        int          exp_lat;
        int          exp_rises;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"status_0c", 1'b1, 1'b0, 32'h0,        8'h0C, 40'h01,         1, 80,  8,  1'b0};
        vecs[1] = '{"write_dd",  1'b0, 1'b1, 32'hDDCCBBAA, 8'h10, 40'h02AABBCCDD, 5, 336, 40, 1'b1};
        vecs[2] = '{"write_12",  1'b0, 1'b1, 32'h12345678, 8'hFF, 40'h0278563412, 5, 336, 40, 1'b1};
        vecs[3] = '{"status_a5", 1'b1, 1'b0, 32'h0,        8'hA5, 40'h01,         1, 80,  8,  1'b0};
        vecs[4] = '{"write_00",  1'b0, 1'b1, 32'h00FF8001, 8'h81, 40'h020180FF00, 5, 336, 40, 1'b1};

        rst_n      = 1'b0;
        seg_valid  = 1'b0;
        seg_data   = '0;
        status_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst spi_cs",     {63'd0, spi_cs},     64'd1);
        check("rst spi_sck",    {63'd0, spi_sck},    64'd0);
        check("rst spi_mosi",   {63'd0, spi_mosi},   64'd0);
        check("rst busy",       {63'd0, busy},       64'd0);
        check("rst done",       {63'd0, done},       64'd0);
        check("rst free_slots", {56'd0, free_slots}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle spi_cs", {63'd0, spi_cs}, 64'd1);

        // Table-driven transactions.
        for (int v = 0; v < 5; v++) begin
            status_req = vecs[v].req_status;
            seg_valid  = vecs[v].req_write;
            seg_data   = vecs[v].data;
            model_free = vecs[v].mfree;
            observe(vecs[v].name, vecs[v].exp_mosi, vecs[v].exp_nbytes, vecs[v].mfree,
                    vecs[v].exp_lat, vecs[v].exp_rises, vecs[v].exp_ready, 1'b0);
            repeat (3) @(negedge clk);
        end

        // Status and write requested together: status first, write right after.
        status_req = 1'b1;
        seg_valid  = 1'b1;
        seg_data   = 32'h44332211;
        model_free = 8'h07;
        observe("arb_status", 40'h01, 1, 8'h07, 80, 8, 1'b0, 1'b0);
        // The seg_data change after the write starts must not reach MOSI.
        observe("arb_write", 40'h0211223344, 5, 8'h07, 336, 40, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Reset during payload byte 2: nothing acknowledged, record resent.
        seg_valid  = 1'b1;
        seg_data   = 32'hDDCCBBAA;
        model_free = 8'h08;
        begin
            int qstart;
            qstart = cap_q.size();
            @(negedge clk);
            check("rstmid cs_fall", {63'd0, spi_cs}, 64'd0);
            repeat (199) begin
                @(negedge clk);
                if (seg_ready === 1'b1) check("rstmid early seg_ready", 64'd1, 64'd0);
            end
            check("rstmid bytes_before", 64'(cap_q.size() - qstart), 64'd3);
            rst_n = 1'b0;
            #1;
            check("rstmid spi_cs",     {63'd0, spi_cs},     64'd1);
            check("rstmid spi_sck",    {63'd0, spi_sck},    64'd0);
            check("rstmid busy",       {63'd0, busy},       64'd0);
            check("rstmid seg_ready",  {63'd0, seg_ready},  64'd0);
            check("rstmid free_slots", {56'd0, free_slots}, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        observe("rstmid resend", 40'h02AABBCCDD, 5, 8'h08, 336, 40, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Secondary reports a full FIFO on the command byte of a write.
        seg_valid  = 1'b1;
        seg_data   = 32'hCAFEF00D;
        model_free = 8'h00;
`ifdef BEAGLEG_SPI_HOST_FULL_CHECK_EN
        observe("full abort", 40'h02, 1, 8'h00, 80, 8, 1'b0, 1'b1);
        // Segment stays pending; the retry starts right after done.
        model_free = 8'h03;
        observe("full retry", 40'h020DF0FECA, 5, 8'h03, 336, 40, 1'b1, 1'b0);
`else
        observe("full nocheck", 40'h020DF0FECA, 5, 8'h00, 336, 40, 1'b1, 1'b0);
`endif
        repeat (3) @(negedge clk);
        check("end idle cs", {63'd0, spi_cs}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beagleg_spi_host.md
# beagleg_spi_host

SPI main-side transmitter for the BeagleG motion protocol. It drives the link that the motion FPGA's SPI secondary receives: it issues `CMD_STATUS` and `CMD_WRITE_FIFO` transactions and shifts motion-segment records out on MOSI. It captures the free-slot count the secondary returns during every command byte. It sits in bench/bridge designs that feed the motion FPGA from fabric, with segments arriving over a valid/ready stream.

## Interface
- `ClkDiv`, default 4: SCK half-period in `clk` cycles; legal range ≥ 2.
- `RecordWords`, default 4: bytes per motion segment; must match the secondary's FIFO record size.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seg_valid`  in  1  segment offered.
- `seg_ready`  out  1  one-cycle pulse; the segment is accepted and fully transmitted.
- `seg_data`  in  8*RecordWords  segment payload; byte 0 = bits [7:0].
- `status_req`  in  1  request a status poll; level-sampled while idle.
- `done`  out  1  one-cycle pulse at the end of every transaction.
- `aborted`  out  1  one-cycle pulse coincident with `done` when a write was abandoned because the secondary FIFO was full.
- `free_slots`  out  8  last free-slot count received.
- `busy`  out  1  high from transaction start until `done`.
- `spi_sck`  out  1  SPI clock; idles low.
- `spi_mosi`  out  1  main-out data, MSB first.
- `spi_cs`  out  1  chip select; active low.
- `spi_miso`  in  1  secondary-out data.

## Operation
- SPI mode 0: MOSI changes while SCK is low; MISO is sampled on the `clk` cycle in which SCK rises. Bytes are sent MSB first.
- Command codes: `CMD_NO_OP`=0, `CMD_STATUS`=1, `CMD_WRITE_FIFO`=2.
- Every transaction starts with one command byte. The byte received during it is latched into `free_slots` after bit 0.
- Arbitration in IDLE: `status_req` has priority over `seg_valid`.
- Status transaction: command 1 only, then CS release.
- Write transaction:
  - Command 2, then RecordWords payload bytes, byte 0 first.
  - `seg_data` is registered at transaction start, so the input may change afterwards.
  - `seg_ready` pulses together with `done`.
- States and transitions:
  - IDLE → CS_SETUP on a request.
  - CS_SETUP: CS low, SCK low, lasting ClkDiv cycles → SHIFT.
  - SHIFT: 8 bits × 2·ClkDiv cycles → BYTE_END.
  - BYTE_END → SHIFT if bytes remain, else → CS_HOLD.
  - CS_HOLD: ClkDiv cycles with CS still low → CS_IDLE.
  - CS_IDLE: CS high for 2·ClkDiv cycles → IDLE; `done` pulses on entry to IDLE.
- Counters:
  - Divider: $clog2(ClkDiv) bits, wraps at ClkDiv-1.
  - Bit counter: 3 bits.
  - Byte counter: $clog2(RecordWords+1) bits, counts from 0 to RecordWords.
- Reset values: `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `seg_ready`=0, `done`=0, `aborted`=0, `busy`=0, `free_slots`=0, state IDLE. All counters reset to 0.
- Reset mid-transaction: all outputs return to reset values immediately. The segment is not acknowledged, and the secondary returns to idle because CS is high.
- `status_req` and `seg_valid` both high: the status poll runs first. The write starts in the cycle after `done` if `seg_valid` is still high.

## Timing
- Start latency: CS falls on the first `clk` edge after the request is sampled in IDLE.
- Byte duration: 16·ClkDiv cycles.
- Status transaction, CS fall to `done`: ClkDiv + 16·ClkDiv + ClkDiv + 2·ClkDiv = 20·ClkDiv cycles, which is 80 cycles at ClkDiv=4.
- Full write: 20·ClkDiv + RecordWords·16·ClkDiv cycles, which is 336 cycles at the defaults.
- BYTE_END takes zero cycles: consecutive bytes are back-to-back, with no extra SCK gap.
- `busy` falls in the same cycle that `done` pulses.
- ClkDiv ≥ 4 is required when the secondary oversamples SCK in its own clock domain.

## Configuration
- `BEAGLEG_SPI_HOST_FULL_CHECK_EN` defined:
  - After the command byte of a write, if the latched `free_slots`==0, no payload bytes are sent and the state goes to CS_HOLD.
  - `aborted` and `done` pulse; `seg_ready` stays low and the segment remains pending.
- Not defined:
  - The payload is always sent; `aborted` is tied to 0.
  - The user must poll status before writing.

## Test plan
- Reset while IDLE: `spi_cs`=1, `spi_sck`=0, `busy`=0, `free_slots`=0.
- `status_req` with the model secondary returning 0x0C, ClkDiv=4: MOSI carries 0x01; `free_slots`=0x0C; `done` 80 cycles after CS falls; exactly 8 SCK rising edges.
- `seg_valid` with `seg_data`=0xDDCCBBAA and model free=16: MOSI carries 02 AA BB CC DD; `seg_ready` and `done` pulse together; 40 SCK rising edges.
- `status_req` and `seg_valid` raised in the same cycle: status completes first, then the write starts one cycle after `done`.
- Full check enabled, model returns 0: only 8 SCK edges; `aborted`=1 and `seg_ready`=0; a retry after the model returns 3 sends the full record.
- `rst_n` asserted during payload byte 2: CS rises immediately; no `seg_ready`; the next write resends the whole record from the command byte.
